// File: rtl/bp_cce_mem_scoreboard_if.sv
// Handshake bundle on the CCE<->memory boundary as seen by the in-order scoreboard.
interface bp_cce_mem_scoreboard_if #(
    parameter int unsigned paddr_width_p = 39,
    parameter int unsigned num_lce_p     = 8,
    parameter int unsigned lce_assoc_p   = 8
);
    localparam int unsigned LgLce = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int unsigned LgWay = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;

    // mem_cmd (read) and mem_data_cmd (writeback)
    logic                     rd_cmd_v;
    logic                     rd_cmd_ready;
    logic [paddr_width_p-1:0] rd_cmd_addr;
    logic [LgLce-1:0]         rd_cmd_lce;
    logic [LgWay-1:0]         rd_cmd_way;
    logic                     rd_cmd_nc;

    logic                     wr_cmd_v;
    logic                     wr_cmd_ready;
    logic [paddr_width_p-1:0] wr_cmd_addr;
    logic                     wr_cmd_nc;

    // mem_data_resp (read) and mem_resp (writeback ack)
    logic                     rd_resp_v;
    logic                     rd_resp_yumi;
    logic [paddr_width_p-1:0] rd_resp_addr;
    logic [LgLce-1:0]         rd_resp_lce;
    logic [LgWay-1:0]         rd_resp_way;
    logic                     rd_resp_nc;

    logic                     wr_resp_v;
    logic                     wr_resp_yumi;
    logic [paddr_width_p-1:0] wr_resp_addr;
    logic                     wr_resp_nc;

    modport master (
        output rd_cmd_v, rd_cmd_ready, rd_cmd_addr, rd_cmd_lce, rd_cmd_way, rd_cmd_nc,
        output wr_cmd_v, wr_cmd_ready, wr_cmd_addr, wr_cmd_nc,
        output rd_resp_v, rd_resp_yumi, rd_resp_addr, rd_resp_lce, rd_resp_way, rd_resp_nc,
        output wr_resp_v, wr_resp_yumi, wr_resp_addr, wr_resp_nc
    );

    modport slave (
        input rd_cmd_v, rd_cmd_ready, rd_cmd_addr, rd_cmd_lce, rd_cmd_way, rd_cmd_nc,
        input wr_cmd_v, wr_cmd_ready, wr_cmd_addr, wr_cmd_nc,
        input rd_resp_v, rd_resp_yumi, rd_resp_addr, rd_resp_lce, rd_resp_way, rd_resp_nc,
        input wr_resp_v, wr_resp_yumi, wr_resp_addr, wr_resp_nc
    );
endinterface

// File: rtl/bp_cce_mem_scoreboard.sv
// In-order CCE<->memory scoreboard: tracks outstanding read/write commands, checks each
// response against the oldest command of its class and latches the first error seen.
module bp_cce_mem_scoreboard #(
    parameter int unsigned paddr_width_p     = 39,
    parameter int unsigned num_lce_p         = 8,
    parameter int unsigned lce_assoc_p       = 8,
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned timeout_p         = 1024,
    localparam int unsigned Cw = $clog2(max_outstanding_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    bp_cce_mem_scoreboard_if.slave   bus_io,
    output logic [Cw-1:0]            rd_outstanding_o,
    output logic [Cw-1:0]            wr_outstanding_o,
    output logic                     idle_o,
    output logic                     error_o,
    output logic [2:0]               error_code_o,
    output logic [paddr_width_p-1:0] error_addr_o
);
    localparam int unsigned LgLce = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int unsigned LgWay = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
    localparam int unsigned Pw    = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int unsigned Aw    = $clog2(timeout_p + 1);

    typedef struct packed {
        logic [paddr_width_p-1:0] addr;
        logic [LgLce-1:0]         lce;
        logic [LgWay-1:0]         way;
        logic                     nc;
    } rd_entry_t;

    typedef struct packed {
        logic [paddr_width_p-1:0] addr;
        logic                     nc;
    } wr_entry_t;

    // ---------------------------------------------------------------------------------------
    // Read tracking FIFO
    // ---------------------------------------------------------------------------------------
    rd_entry_t      rd_mem_q [max_outstanding_p];
    logic [Pw-1:0]  rd_head_q, rd_head_d, rd_tail_q, rd_tail_d;
    logic [Cw-1:0]  rd_cnt_q, rd_cnt_d;
    logic [Aw-1:0]  rd_age_q, rd_age_d;
    rd_entry_t      rd_cmd_ent, rd_resp_ent, rd_head_ent;
    logic           rd_push_req, rd_pop_req, rd_empty, rd_full;
    logic           rd_do_push, rd_do_pop;
    logic           rd_ovf, rd_unexp, rd_mm, rd_to;

    assign rd_cmd_ent  = '{addr: bus_io.rd_cmd_addr, lce: bus_io.rd_cmd_lce,
                           way: bus_io.rd_cmd_way, nc: bus_io.rd_cmd_nc};
    assign rd_resp_ent = '{addr: bus_io.rd_resp_addr, lce: bus_io.rd_resp_lce,
                           way: bus_io.rd_resp_way, nc: bus_io.rd_resp_nc};
    assign rd_head_ent = rd_mem_q[rd_head_q];

    assign rd_push_req = bus_io.rd_cmd_v & bus_io.rd_cmd_ready;
    assign rd_pop_req  = bus_io.rd_resp_v & bus_io.rd_resp_yumi;
    assign rd_empty    = (rd_cnt_q == '0);
    assign rd_full     = (rd_cnt_q == Cw'(max_outstanding_p));

    // Pop is judged against pre-push state; a full FIFO accepts a push only alongside a pop.
    assign rd_do_pop  = rd_pop_req & ~rd_empty;
    assign rd_unexp   = rd_pop_req & rd_empty;
    assign rd_do_push = rd_push_req & (~rd_full | rd_do_pop);
    assign rd_ovf     = rd_push_req & rd_full & ~rd_do_pop;
    assign rd_mm      = rd_do_pop & (rd_head_ent != rd_resp_ent);
    assign rd_to      = ~rd_do_pop & ~rd_empty & (rd_age_q == Aw'(timeout_p - 1));

    always_comb begin
        rd_head_d = rd_head_q;
        rd_tail_d = rd_tail_q;
        if (rd_do_pop) begin
            rd_head_d = (rd_head_q == Pw'(max_outstanding_p - 1)) ? '0 : rd_head_q + 1'b1;
        end
        if (rd_do_push) begin
            rd_tail_d = (rd_tail_q == Pw'(max_outstanding_p - 1)) ? '0 : rd_tail_q + 1'b1;
        end
        rd_cnt_d = rd_cnt_q + Cw'(rd_do_push) - Cw'(rd_do_pop);

        rd_age_d = rd_age_q;
        if (rd_do_pop || rd_empty) begin
            rd_age_d = '0;
        end else if (rd_age_q != Aw'(timeout_p)) begin
            rd_age_d = rd_age_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_head_q <= '0;
            rd_tail_q <= '0;
            rd_cnt_q  <= '0;
            rd_age_q  <= '0;
            for (int i = 0; i < int'(max_outstanding_p); i++) begin
                rd_mem_q[i] <= '0;
            end
        end else begin
            rd_head_q <= rd_head_d;
            rd_tail_q <= rd_tail_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_age_q  <= rd_age_d;
            if (rd_do_push) begin
                rd_mem_q[rd_tail_q] <= rd_cmd_ent;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Write tracking FIFO
    // ---------------------------------------------------------------------------------------
    wr_entry_t      wr_mem_q [max_outstanding_p];
    logic [Pw-1:0]  wr_head_q, wr_head_d, wr_tail_q, wr_tail_d;
    logic [Cw-1:0]  wr_cnt_q, wr_cnt_d;
    logic [Aw-1:0]  wr_age_q, wr_age_d;
    wr_entry_t      wr_cmd_ent, wr_resp_ent, wr_head_ent;
    logic           wr_push_req, wr_pop_req, wr_empty, wr_full;
    logic           wr_do_push, wr_do_pop;
    logic           wr_ovf, wr_unexp, wr_mm, wr_to;

    assign wr_cmd_ent  = '{addr: bus_io.wr_cmd_addr, nc: bus_io.wr_cmd_nc};
    assign wr_resp_ent = '{addr: bus_io.wr_resp_addr, nc: bus_io.wr_resp_nc};
    assign wr_head_ent = wr_mem_q[wr_head_q];

    assign wr_push_req = bus_io.wr_cmd_v & bus_io.wr_cmd_ready;
    assign wr_pop_req  = bus_io.wr_resp_v & bus_io.wr_resp_yumi;
    assign wr_empty    = (wr_cnt_q == '0);
    assign wr_full     = (wr_cnt_q == Cw'(max_outstanding_p));

    assign wr_do_pop  = wr_pop_req & ~wr_empty;
    assign wr_unexp   = wr_pop_req & wr_empty;
    assign wr_do_push = wr_push_req & (~wr_full | wr_do_pop);
    assign wr_ovf     = wr_push_req & wr_full & ~wr_do_pop;
    assign wr_mm      = wr_do_pop & (wr_head_ent != wr_resp_ent);
    assign wr_to      = ~wr_do_pop & ~wr_empty & (wr_age_q == Aw'(timeout_p - 1));

    always_comb begin
        wr_head_d = wr_head_q;
        wr_tail_d = wr_tail_q;
        if (wr_do_pop) begin
            wr_head_d = (wr_head_q == Pw'(max_outstanding_p - 1)) ? '0 : wr_head_q + 1'b1;
        end
        if (wr_do_push) begin
            wr_tail_d = (wr_tail_q == Pw'(max_outstanding_p - 1)) ? '0 : wr_tail_q + 1'b1;
        end
        wr_cnt_d = wr_cnt_q + Cw'(wr_do_push) - Cw'(wr_do_pop);

        wr_age_d = wr_age_q;
        if (wr_do_pop || wr_empty) begin
            wr_age_d = '0;
        end else if (wr_age_q != Aw'(timeout_p)) begin
            wr_age_d = wr_age_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_head_q <= '0;
            wr_tail_q <= '0;
            wr_cnt_q  <= '0;
            wr_age_q  <= '0;
            for (int i = 0; i < int'(max_outstanding_p); i++) begin
                wr_mem_q[i] <= '0;
            end
        end else begin
            wr_head_q <= wr_head_d;
            wr_tail_q <= wr_tail_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_age_q  <= wr_age_d;
            if (wr_do_push) begin
                wr_mem_q[wr_tail_q] <= wr_cmd_ent;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // First-error latch; lowest code wins when several errors coincide
    // ---------------------------------------------------------------------------------------
    logic                     err_q, err_d, err_set;
    logic [2:0]               code_q, code_d, code_new;
    logic [paddr_width_p-1:0] addr_q, addr_d, addr_new;

    always_comb begin
        err_set  = 1'b1;
        code_new = 3'd0;
        addr_new = '0;
        if (rd_ovf) begin
            code_new = 3'd1;
            addr_new = bus_io.rd_cmd_addr;
        end else if (wr_ovf) begin
            code_new = 3'd2;
            addr_new = bus_io.wr_cmd_addr;
        end else if (rd_unexp) begin
            code_new = 3'd3;
            addr_new = bus_io.rd_resp_addr;
        end else if (wr_unexp) begin
            code_new = 3'd4;
            addr_new = bus_io.wr_resp_addr;
        end else if (rd_mm) begin
            code_new = 3'd5;
            addr_new = bus_io.rd_resp_addr;
        end else if (wr_mm) begin
            code_new = 3'd6;
            addr_new = bus_io.wr_resp_addr;
        end else if (rd_to || wr_to) begin
            code_new = 3'd7;
            addr_new = rd_to ? rd_head_ent.addr : wr_head_ent.addr;
        end else begin
            err_set = 1'b0;
        end

        err_d  = err_q;
        code_d = code_q;
        addr_d = addr_q;
        if (clear_i) begin
            err_d  = 1'b0;
            code_d = 3'd0;
            addr_d = '0;
        end else if (!err_q && err_set) begin
            err_d  = 1'b1;
            code_d = code_new;
            addr_d = addr_new;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q  <= 1'b0;
            code_q <= 3'd0;
            addr_q <= '0;
        end else begin
            err_q  <= err_d;
            code_q <= code_d;
            addr_q <= addr_d;
        end
    end

    assign rd_outstanding_o = rd_cnt_q;
    assign wr_outstanding_o = wr_cnt_q;
    assign idle_o           = rd_empty & wr_empty;
    assign error_o          = err_q;
    assign error_code_o     = code_q;
    assign error_addr_o     = addr_q;

endmodule
